// File: rtl/mul_issue_ctrl_if.sv
// Handshake and datapath bundle between decode, the sequential multiplier,
// writeback and the multiply issue controller.
interface mul_issue_ctrl_if #(
  parameter int OP_W = 6,
  parameter int RD_W = 5
);
  logic                req_valid;
  logic                req_ready;
  logic [OP_W-1:0]     req_a;
  logic [OP_W-1:0]     req_b;
  logic [RD_W-1:0]     req_rd;
  logic                mul_start;
  logic [OP_W-1:0]     mul_a;
  logic [OP_W-1:0]     mul_b;
  logic                mul_done;
  logic [2*OP_W-1:0]   mul_product;
  logic                stall;
  logic                wb_valid;
  logic                wb_ready;
  logic [RD_W-1:0]     wb_rd;
  logic [2*OP_W-1:0]   wb_data;
  logic                timeout_err;

  // Controller side.
  modport slave (
    input  req_valid, req_a, req_b, req_rd, mul_done, mul_product, wb_ready,
    output req_ready, mul_start, mul_a, mul_b, stall, wb_valid, wb_rd,
           wb_data, timeout_err
  );

  // Surrounding pipeline / multiplier side.
  modport master (
    output req_valid, req_a, req_b, req_rd, mul_done, mul_product, wb_ready,
    input  req_ready, mul_start, mul_a, mul_b, stall, wb_valid, wb_rd,
           wb_data, timeout_err
  );
endinterface

// File: rtl/mul_issue_ctrl.sv
// Issue/writeback controller for the sequential signed multiplier: latches a
// request, launches the multiplier, guards completion with a timeout.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | ready for a request; zero operand bypasses the multiplier
// ST_LAUNCH | one-cycle mul_start pulse, wait counter cleared
// ST_WAIT   | waiting for mul_done (blanked in first cycle) or timeout
// ST_WB     | product presented to writeback until wb_ready
module mul_issue_ctrl #(
  parameter int OP_W     = 6,
  parameter int RD_W     = 5,
  parameter int MAX_WAIT = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  mul_issue_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_WB     = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    wait_cnt;
  logic [OP_W-1:0]     op_a_q, op_b_q;
  logic [RD_W-1:0]     rd_q;
  logic [2*OP_W-1:0]   data_q;
  logic                timeout_q;
  logic                accept, bypass, capture, timeout;

  assign bypass = (bus.req_a == '0) || (bus.req_b == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    timeout   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          accept    = 1'b1;
          state_nxt = bypass ? ST_WB : ST_LAUNCH;
        end
      end
      ST_LAUNCH: state_nxt = ST_WAIT;
      ST_WAIT: begin
        // Count zero is the first WAIT cycle: a stale done from the previous
        // operation may still be high there, so it is not trusted.
        if ((wait_cnt != '0) && bus.mul_done) begin
          capture   = 1'b1;
          state_nxt = ST_WB;
        end else if (wait_cnt == CNT_W'(MAX_WAIT - 1)) begin
          timeout   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_WB: begin
        if (bus.wb_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt  <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      rd_q      <= '0;
      data_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == ST_LAUNCH)    wait_cnt <= '0;
      else if (state == ST_WAIT) wait_cnt <= wait_cnt + 1'b1;

      if (accept) begin
        op_a_q <= bus.req_a;
        op_b_q <= bus.req_b;
        rd_q   <= bus.req_rd;
        if (bypass) data_q <= '0;
      end

      if (capture) data_q <= bus.mul_product;
      if (timeout) timeout_q <= 1'b1;
    end
  end

  assign bus.req_ready   = (state == ST_IDLE);
  assign bus.stall       = (state != ST_IDLE);
  assign bus.mul_start   = (state == ST_LAUNCH);
  assign bus.wb_valid    = (state == ST_WB);
  assign bus.mul_a       = op_a_q;
  assign bus.mul_b       = op_b_q;
  assign bus.wb_rd       = rd_q;
  assign bus.wb_data     = data_q;
  assign bus.timeout_err = timeout_q;
endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl: normal, bypass, blanking, backpressure,
// timeout and asynchronous reset scenarios with hand-computed expectations.
module tb_mul_issue_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  mul_issue_ctrl_if #(.OP_W(6), .RD_W(5)) bus ();

  mul_issue_ctrl #(.OP_W(6), .RD_W(5), .MAX_WAIT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_reset_values(input string pfx);
    chk({pfx, "_req_ready"},   32'(bus.req_ready),   32'd1);
    chk({pfx, "_mul_start"},   32'(bus.mul_start),   32'd0);
    chk({pfx, "_mul_a"},       32'(bus.mul_a),       32'd0);
    chk({pfx, "_mul_b"},       32'(bus.mul_b),       32'd0);
    chk({pfx, "_stall"},       32'(bus.stall),       32'd0);
    chk({pfx, "_wb_valid"},    32'(bus.wb_valid),    32'd0);
    chk({pfx, "_wb_rd"},       32'(bus.wb_rd),       32'd0);
    chk({pfx, "_wb_data"},     32'(bus.wb_data),     32'd0);
    chk({pfx, "_timeout_err"}, 32'(bus.timeout_err), 32'd0);
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.req_valid   = 1'b0;
    bus.req_a       = '0;
    bus.req_b       = '0;
    bus.req_rd      = '0;
    bus.mul_done    = 1'b0;
    bus.mul_product = '0;
    bus.wb_ready    = 1'b0;
    #2;
    check_reset_values("rst");
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Normal: 3 * -2, done 12 cycles after start.
    bus.req_valid = 1'b1; bus.req_a = 6'd3; bus.req_b = 6'h3E; bus.req_rd = 5'd7;
    chk("norm_req_ready", 32'(bus.req_ready), 32'd1);
    tick();                                   // N+1
    bus.req_valid = 1'b0;
    chk("norm_start",     32'(bus.mul_start), 32'd1);
    chk("norm_mul_a",     32'(bus.mul_a),     32'h03);
    chk("norm_mul_b",     32'(bus.mul_b),     32'h3E);
    chk("norm_stall_l",   32'(bus.stall),     32'd1);
    chk("norm_rdy_l",     32'(bus.req_ready), 32'd0);
    for (int i = 2; i <= 12; i++) begin
      tick();
      chk("norm_start_pulse", 32'(bus.mul_start), 32'd0);
      chk("norm_no_wb",       32'(bus.wb_valid),  32'd0);
      chk("norm_stall",       32'(bus.stall),     32'd1);
    end
    tick();                                   // N+13
    bus.mul_done = 1'b1; bus.mul_product = 12'hFFA;
    tick();                                   // N+14
    bus.mul_done = 1'b0;
    chk("norm_wb_valid", 32'(bus.wb_valid), 32'd1);
    chk("norm_wb_rd",    32'(bus.wb_rd),    32'd7);
    chk("norm_wb_data",  32'(bus.wb_data),  32'hFFA);
    chk("norm_wb_stall", 32'(bus.stall),    32'd1);
    bus.wb_ready = 1'b1;
    tick();
    bus.wb_ready = 1'b0;
    chk("norm_done_valid", 32'(bus.wb_valid),  32'd0);
    chk("norm_done_ready", 32'(bus.req_ready), 32'd1);
    chk("norm_done_stall", 32'(bus.stall),     32'd0);

    // Bypass: zero operand skips the multiplier.
    bus.req_valid = 1'b1; bus.req_a = 6'd0; bus.req_b = 6'd25; bus.req_rd = 5'd4;
    tick();                                   // N+1
    bus.req_valid = 1'b0;
    chk("byp_wb_valid", 32'(bus.wb_valid),  32'd1);
    chk("byp_wb_data",  32'(bus.wb_data),   32'd0);
    chk("byp_wb_rd",    32'(bus.wb_rd),     32'd4);
    chk("byp_no_start", 32'(bus.mul_start), 32'd0);
    bus.wb_ready = 1'b1;
    tick();
    bus.wb_ready = 1'b0;
    chk("byp_no_start2", 32'(bus.mul_start), 32'd0);
    chk("byp_ready",     32'(bus.req_ready), 32'd1);

    // Blanking: stale done through LAUNCH, low from N+2, high again at N+6.
    bus.mul_done = 1'b1; bus.mul_product = 12'h123;
    bus.req_valid = 1'b1; bus.req_a = 6'd5; bus.req_b = 6'd7; bus.req_rd = 5'd3;
    tick();                                   // N+1
    bus.req_valid = 1'b0;
    chk("blk_start",   32'(bus.mul_start), 32'd1);
    chk("blk_no_wb1",  32'(bus.wb_valid),  32'd0);
    tick();                                   // N+2
    bus.mul_done = 1'b0;
    chk("blk_no_wb2",  32'(bus.wb_valid),  32'd0);
    for (int i = 3; i <= 5; i++) begin
      tick();
      chk("blk_no_wb", 32'(bus.wb_valid), 32'd0);
    end
    tick();                                   // N+6
    bus.mul_done = 1'b1; bus.mul_product = 12'h023;
    chk("blk_no_wb6",  32'(bus.wb_valid),  32'd0);
    tick();                                   // N+7
    bus.mul_done = 1'b0;
    chk("blk_wb_valid", 32'(bus.wb_valid), 32'd1);
    chk("blk_wb_data",  32'(bus.wb_data),  32'h023);
    chk("blk_wb_rd",    32'(bus.wb_rd),    32'd3);
    bus.wb_ready = 1'b1;
    tick();
    bus.wb_ready = 1'b0;

    // Done held high through the blanked cycle, then 5 cycles of backpressure.
    bus.mul_done = 1'b1; bus.mul_product = 12'hFFF;
    bus.req_valid = 1'b1; bus.req_a = 6'h3F; bus.req_b = 6'd1; bus.req_rd = 5'd6;
    tick();                                   // N+1
    bus.req_valid = 1'b0;
    chk("hold_no_wb1", 32'(bus.wb_valid), 32'd0);
    tick();                                   // N+2
    chk("hold_no_wb2", 32'(bus.wb_valid), 32'd0);
    tick();                                   // N+3
    chk("hold_no_wb3", 32'(bus.wb_valid), 32'd0);
    tick();                                   // N+4
    bus.mul_done = 1'b0;
    chk("hold_wb_valid", 32'(bus.wb_valid), 32'd1);
    chk("hold_wb_data",  32'(bus.wb_data),  32'hFFF);
    bus.req_valid = 1'b1; bus.req_a = 6'd2; bus.req_b = 6'd2; bus.req_rd = 5'd9;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid",   32'(bus.wb_valid),  32'd1);
      chk("bp_data",    32'(bus.wb_data),   32'hFFF);
      chk("bp_rd",      32'(bus.wb_rd),     32'd6);
      chk("bp_ready",   32'(bus.req_ready), 32'd0);
      chk("bp_nostart", 32'(bus.mul_start), 32'd0);
      tick();
    end                                       // N+9
    bus.wb_ready = 1'b1;
    chk("bp_hs_valid", 32'(bus.wb_valid), 32'd1);
    tick();                                   // N+10
    bus.wb_ready = 1'b0;
    chk("bp_after_valid", 32'(bus.wb_valid),  32'd0);
    chk("bp_after_ready", 32'(bus.req_ready), 32'd1);
    chk("bp_after_start", 32'(bus.mul_start), 32'd0);
    bus.mul_done = 1'b1; bus.mul_product = 12'h004;
    tick();                                   // N+11
    bus.req_valid = 1'b0;
    chk("bp2_start", 32'(bus.mul_start), 32'd1);
    chk("bp2_mul_a", 32'(bus.mul_a),     32'd2);
    tick();                                   // N+12
    chk("bp2_no_wb1", 32'(bus.wb_valid), 32'd0);
    tick();                                   // N+13
    chk("bp2_no_wb2", 32'(bus.wb_valid), 32'd0);
    tick();                                   // N+14
    bus.mul_done = 1'b0;
    chk("bp2_wb_valid", 32'(bus.wb_valid), 32'd1);
    chk("bp2_wb_data",  32'(bus.wb_data),  32'h004);
    chk("bp2_wb_rd",    32'(bus.wb_rd),    32'd9);
    bus.wb_ready = 1'b1;
    tick();
    bus.wb_ready = 1'b0;

    // Timeout: done never arrives; 16 WAIT cycles (N+2..N+17).
    bus.req_valid = 1'b1; bus.req_a = 6'd1; bus.req_b = 6'd1; bus.req_rd = 5'd2;
    tick();                                   // N+1
    bus.req_valid = 1'b0;
    for (int i = 2; i <= 17; i++) begin
      tick();
      chk("to_no_wb",  32'(bus.wb_valid),    32'd0);
      chk("to_no_err", 32'(bus.timeout_err), 32'd0);
      chk("to_stall",  32'(bus.stall),       32'd1);
    end
    tick();                                   // N+18
    chk("to_err",      32'(bus.timeout_err), 32'd1);
    chk("to_idle",     32'(bus.stall),       32'd0);
    chk("to_ready",    32'(bus.req_ready),   32'd1);
    chk("to_no_wb_e",  32'(bus.wb_valid),    32'd0);
    bus.req_valid = 1'b1; bus.req_a = 6'd2; bus.req_b = 6'd3; bus.req_rd = 5'd1;
    tick();                                   // M+1
    bus.req_valid = 1'b0;
    bus.mul_done = 1'b1; bus.mul_product = 12'h006;
    tick();                                   // M+2
    tick();                                   // M+3
    tick();                                   // M+4
    bus.mul_done = 1'b0;
    chk("to_next_valid", 32'(bus.wb_valid),    32'd1);
    chk("to_next_data",  32'(bus.wb_data),     32'h006);
    chk("to_next_rd",    32'(bus.wb_rd),       32'd1);
    chk("to_err_sticky", 32'(bus.timeout_err), 32'd1);
    bus.wb_ready = 1'b1;
    tick();
    bus.wb_ready = 1'b0;

    // Asynchronous reset in the middle of WAIT.
    bus.req_valid = 1'b1; bus.req_a = 6'd3; bus.req_b = 6'd3; bus.req_rd = 5'd5;
    tick();                                   // N+1
    bus.req_valid = 1'b0;
    tick();                                   // N+2
    tick();                                   // N+3
    chk("mid_stall", 32'(bus.stall), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("mid_rst");
    tick();
    rst_n = 1'b1;
    tick();
    bus.req_valid = 1'b1; bus.req_a = 6'h3D; bus.req_b = 6'h3D; bus.req_rd = 5'd5;
    tick();                                   // N+1
    bus.req_valid = 1'b0;
    chk("post_start", 32'(bus.mul_start), 32'd1);
    chk("post_mul_a", 32'(bus.mul_a),     32'h3D);
    tick();                                   // N+2
    tick();                                   // N+3
    bus.mul_done = 1'b1; bus.mul_product = 12'h009;
    tick();                                   // N+4
    bus.mul_done = 1'b0;
    chk("post_wb_valid", 32'(bus.wb_valid), 32'd1);
    chk("post_wb_data",  32'(bus.wb_data),  32'h009);
    chk("post_wb_rd",    32'(bus.wb_rd),    32'd5);
    bus.wb_ready = 1'b1;
    tick();
    bus.wb_ready = 1'b0;
    chk("post_ready", 32'(bus.req_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
